// File: rtl/aes128_pkg.sv
// Shared AES-128 definitions: S-box lookup, GF(2^8) doubling, round constants, FSM states.
// Latency: not applicable (package only, no logic of its own).
// Backpressure: not applicable.
// Contents: NUM_ROUNDS, RCON_INIT, aes_state_e, sbox(), xtime().
package aes128_pkg;

    localparam int         NUM_ROUNDS = 10;
    localparam logic [7:0] RCON_INIT  = 8'h01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[2047 - 8 * int'(x) -: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes128_round.sv
// One AES-128 encryption round plus the matching key-schedule step, purely combinational.
// Latency: 0 cycles (combinational).
// Backpressure: none; the parent decides when results are registered.
// Ports: state_in/key_in = round input state and previous round key; rcon_in = round constant
//        for this step; last_round skips MixColumns; state_out/key_out = round result and key used.
module aes128_round
    import aes128_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] key_in,
    input  logic [7:0]   rcon_in,
    input  logic         last_round,
    output logic [127:0] state_out,
    output logic [127:0] key_out
);

    // Next round key: w[i] = w[i-4] ^ w[i-1], with RotWord/SubWord/rcon on the first word.
    logic [31:0] w0, w1, w2, w3, t;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = key_in[127:96];
    assign w1 = key_in[95:64];
    assign w2 = key_in[63:32];
    assign w3 = key_in[31:0];
    assign t  = {sbox(w3[23:16]) ^ rcon_in, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign key_out = {n0, n1, n2, n3};

    // Byte b sits at bits [127-8b -: 8]; column c = b/4, row r = b%4.
    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    for (genvar b = 0; b < 16; b++) begin : g_byte
        assign sb[b] = sbox(state_in[127-8*b -: 8]);
        // ShiftRows: row r rotates left by r columns, i.e. source index b + 4r mod 16.
        assign sr[b] = sb[(b + 4 * (b % 4)) % 16];
        assign state_out[127-8*b -: 8] = (last_round ? sr[b] : mc[b]) ^ key_out[127-8*b -: 8];
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
        assign mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end

endmodule

// File: rtl/aes128_iter.sv
// Iterative AES-128 encryptor, ROUNDS_PER_CYCLE rounds per clock (1, 2, 5 or 10).
// Latency: out_valid rises 10/ROUNDS_PER_CYCLE edges after the accept edge.
// Backpressure: one block at a time; result held in DONE until out_ready, in_ready low meanwhile.
// Ports: clk, rst (async active-low); in_valid/in_ready/in_data/in_key request side;
//        out_valid/out_ready/out_data result side; ctr_load/ctr_init with AES128_ITER_CTR_EN.
// Build option: define AES128_ITER_CTR_EN for counter mode (out = E(key, ctr) ^ in_data).
module aes128_iter
    import aes128_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
`ifdef AES128_ITER_CTR_EN
    ,
    input  logic         ctr_load,
    input  logic [127:0] ctr_init
`endif
);

    localparam int         RPC      = ROUNDS_PER_CYCLE;
    localparam logic [3:0] RND_STEP = 4'(RPC);
    // Counter value at the start of the edge that computes round 10.
    localparam logic [3:0] RND_LAST = 4'(NUM_ROUNDS + 1 - RPC);

    if (!(RPC == 1 || RPC == 2 || RPC == 5 || RPC == 10)) begin : g_bad_rpc
        $error("aes128_iter: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end

    aes_state_e   state_q, state_d;
    logic [127:0] blk_q, key_q, out_q;
    logic [7:0]   rcon_q;
    logic [3:0]   rnd_q;
    logic         accept;
    logic [127:0] src_blk;
    logic [127:0] out_mask;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_q;
    assign accept    = in_valid && in_ready;

`ifdef AES128_ITER_CTR_EN
    logic [127:0] ctr_q, din_q;

    assign src_blk  = ctr_q;
    assign out_mask = din_q;

    // Load beats increment; both only possible while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctr_q <= '0;
            din_q <= '0;
        end else if (in_ready) begin
            if (ctr_load) begin
                ctr_q <= ctr_init;
            end else if (accept) begin
                ctr_q <= ctr_q + 128'd1;
            end
            if (accept) begin
                din_q <= in_data;
            end
        end
    end
`else
    assign src_blk  = in_data;
    assign out_mask = '0;
`endif

    // Round chain: stage i computes round rnd_q + i.
    logic [127:0] st [RPC+1];
    logic [127:0] ky [RPC+1];
    logic [7:0]   rc [RPC+1];

    assign st[0] = blk_q;
    assign ky[0] = key_q;
    assign rc[0] = rcon_q;

    for (genvar i = 0; i < RPC; i++) begin : g_round
        logic last;
        assign last     = ((rnd_q + 4'(i)) == 4'(NUM_ROUNDS));
        assign rc[i+1]  = xtime(rc[i]);

        aes128_round u_round (
            .state_in   (st[i]),
            .key_in     (ky[i]),
            .rcon_in    (rc[i]),
            .last_round (last),
            .state_out  (st[i+1]),
            .key_out    (ky[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)          state_d = RUN;
            RUN:     if (rnd_q == RND_LAST) state_d = DONE;
            DONE:    if (out_ready)         state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_q  <= '0;
            key_q  <= '0;
            out_q  <= '0;
            rcon_q <= RCON_INIT;
            rnd_q  <= '0;
        end else if (accept) begin
            blk_q  <= src_blk ^ in_key;
            key_q  <= in_key;
            rcon_q <= RCON_INIT;
            rnd_q  <= 4'd1;
        end else if (state_q == RUN) begin
            blk_q  <= st[RPC];
            key_q  <= ky[RPC];
            rcon_q <= rc[RPC];
            rnd_q  <= rnd_q + RND_STEP;
            if (rnd_q == RND_LAST) begin
                out_q <= st[RPC] ^ out_mask;
            end
        end
    end

endmodule
